// File: rtl/ipsxe_floating_point_sqrt_prep_v1_0_pkg.sv
// Shared definitions for the floating-point square-root front end:
// result class encodings plus helpers for the exponent bias and sideband width.
package ipsxe_floating_point_sqrt_prep_v1_0_pkg;

   typedef enum logic [1:0] {
      CLS_NORMAL = 2'd0,
      CLS_ZERO   = 2'd1,
      CLS_INF    = 2'd2,
      CLS_NAN    = 2'd3
   } sqrt_class_e;

   function automatic int sqrt_bias(input int exp_width);
      return (1 << (exp_width - 1)) - 1;
   endfunction

   // Sideband word: {valid, sign, exp, class[1:0], invalid}
   function automatic int sqrt_side_width(input int exp_width);
      return exp_width + 5;
   endfunction

endpackage

// File: rtl/ipsxe_floating_point_register_v1_0.sv
// Generic enabled pipeline register with synchronous active-low clear.
module ipsxe_floating_point_register_v1_0 #(
   parameter int WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_aclken,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_q;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n)
         r_q <= '0;
      else if (i_aclken)
         r_q <= i_d;
   end

   assign o_q = r_q;

endmodule

// File: rtl/ipsxe_floating_point_sqrt_prep_v1_0_side_dly.sv
// Sideband delay line; reset clears every tap so no stale valid survives a reset.
module ipsxe_floating_point_sqrt_side_dly_v1_0 #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_aclken,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   generate
      if (DEPTH == 0) begin : g_wire
         assign o_q = i_d;
      end else begin : g_pipe
         logic [WIDTH-1:0] r_pipe [DEPTH];

         always_ff @(posedge i_clk) begin
            if (!i_rst_n) begin
               for (int k = 0; k < DEPTH; k++)
                  r_pipe[k] <= '0;
            end else if (i_aclken) begin
               r_pipe[0] <= i_d;
               for (int k = 1; k < DEPTH; k++)
                  r_pipe[k] <= r_pipe[k-1];
            end
         end

         assign o_q = r_pipe[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/ipsxe_floating_point_sqrt_prep_v1_0.sv
// Square-root front end: classify, normalise subnormals, fix exponent parity,
// emit the radicand and a delayed sideband (sign/exponent/class) for the back end.
module ipsxe_floating_point_sqrt_prep_v1_0
   import ipsxe_floating_point_sqrt_prep_v1_0_pkg::*;
#(
   parameter int EXP_WIDTH     = 11,
   parameter int MANTISSA_SIZE = 52,
   parameter int BINARY_SIZE   = 106,
   parameter int SIDE_DELAY    = 56
) (
   input  logic                               i_clk,
   input  logic                               i_rst_n,
   input  logic                               i_aclken,
   input  logic                               i_valid,
   input  logic [EXP_WIDTH+MANTISSA_SIZE:0]   i_a,
   output logic [BINARY_SIZE-1:0]             o_radicand,
   output logic                               o_rad_valid,
   output logic                               o_side_valid,
   output logic                               o_side_sign,
   output logic [EXP_WIDTH-1:0]               o_side_exp,
   output logic [1:0]                         o_side_class,
   output logic                               o_side_invalid
);

   localparam int W   = 1 + EXP_WIDTH + MANTISSA_SIZE;
   localparam int SW  = sqrt_side_width(EXP_WIDTH);
   localparam int LZW = $clog2(MANTISSA_SIZE + 1);
   localparam int EW  = EXP_WIDTH + 2;
   localparam logic signed [EW-1:0]  BIAS_S = EW'(sqrt_bias(EXP_WIDTH));
   localparam logic        [LZW-1:0] LZ_ONE = LZW'(1);

   function automatic logic [LZW-1:0] f_lzc(input logic [MANTISSA_SIZE-1:0] v);
      logic found;
      f_lzc = '0;
      found = 1'b0;
      for (int k = MANTISSA_SIZE - 1; k >= 0; k--) begin
         if (!found) begin
            if (v[k]) found = 1'b1;
            else      f_lzc = f_lzc + LZ_ONE;
         end
      end
   endfunction

   logic                     w_s1_valid;
   logic [W-1:0]             w_s1_a;
   logic                     w_sign;
   logic [EXP_WIDTH-1:0]     w_exp;
   logic [MANTISSA_SIZE-1:0] w_frac;
   logic                     w_exp_zero, w_exp_ones, w_frac_zero;
   logic [LZW-1:0]           w_lz;
   logic [MANTISSA_SIZE:0]   w_sig;
   logic signed [EW-1:0]     w_e_eff, w_e_sum;
   logic [BINARY_SIZE-1:0]   w_rad;
   logic [EXP_WIDTH-1:0]     w_exp_out;
   logic                     w_sign_out, w_invalid;
   sqrt_class_e              w_class;
   logic [SW-1:0]            w_side_d, w_side_s2, w_side_out;

   ipsxe_floating_point_register_v1_0 #(.WIDTH(W + 1)) u_s1 (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_aclken(i_aclken),
      .i_d({i_valid, i_a}), .o_q({w_s1_valid, w_s1_a})
   );

   assign {w_sign, w_exp, w_frac} = w_s1_a;
   assign w_exp_zero  = (w_exp == '0);
   assign w_exp_ones  = (w_exp == '1);
   assign w_frac_zero = (w_frac == '0);
   assign w_lz        = f_lzc(w_frac);

   always_comb begin
      w_class   = CLS_NORMAL;
      w_invalid = 1'b0;
      if (w_exp_ones && !w_frac_zero) begin
         w_class = CLS_NAN;
      end else if (w_sign && !(w_exp_zero && w_frac_zero)) begin
         w_class   = CLS_NAN;
         w_invalid = 1'b1;
      end else if (w_exp_ones) begin
         w_class = CLS_INF;
      end else if (w_exp_zero && w_frac_zero) begin
         w_class = CLS_ZERO;
      end
   end

   // Subnormals are left-justified so the hidden-bit position is always set.
   always_comb begin
      if (w_exp_zero) begin
         w_sig   = ({1'b0, w_frac} << w_lz) << 1;
         w_e_eff = EW'(0) - {{(EW - LZW){1'b0}}, w_lz};
      end else begin
         w_sig   = {1'b1, w_frac};
         w_e_eff = {2'b00, w_exp};
      end
   end

   assign w_e_sum = w_e_eff + BIAS_S;

   // Even E_eff means the unbiased exponent is odd: shift one extra place.
   always_comb begin
      w_rad      = '0;
      w_exp_out  = EXP_WIDTH'(w_e_sum >>> 1);
      w_sign_out = 1'b0;
      case (w_class)
         CLS_NORMAL: begin
            if (!w_e_eff[0]) w_rad = {w_sig, {(MANTISSA_SIZE + 1){1'b0}}};
            else             w_rad = {1'b0, w_sig, {MANTISSA_SIZE{1'b0}}};
         end
         CLS_ZERO: begin
            w_exp_out  = '0;
            w_sign_out = w_sign;
         end
         default: w_exp_out = '1;
      endcase
   end

   assign w_side_d = {w_s1_valid, w_sign_out, w_exp_out, w_class, w_invalid};

   ipsxe_floating_point_register_v1_0 #(.WIDTH(BINARY_SIZE + 1)) u_s2_rad (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_aclken(i_aclken),
      .i_d({w_s1_valid, w_rad}), .o_q({o_rad_valid, o_radicand})
   );

   ipsxe_floating_point_register_v1_0 #(.WIDTH(SW)) u_s2_side (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_aclken(i_aclken),
      .i_d(w_side_d), .o_q(w_side_s2)
   );

   ipsxe_floating_point_sqrt_side_dly_v1_0 #(.WIDTH(SW), .DEPTH(SIDE_DELAY)) u_side_dly (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_aclken(i_aclken),
      .i_d(w_side_s2), .o_q(w_side_out)
   );

   assign {o_side_valid, o_side_sign, o_side_exp, o_side_class, o_side_invalid} = w_side_out;

endmodule
